// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions for the receive deframer and the transmit framer.
//   - Frame format encodings carried on cfg_i.
//   - Receive FSM state encoding.
//   - DIV_MIN: smallest usable clocks-per-bit value.
// ---------------------------------------------------------------------------
package uart_pkg;

  // Frame formats: 8 data bits, then optional parity, then 1 or 2 stop bits.
  localparam logic [1:0] UART_8N1 = 2'b00;
  localparam logic [1:0] UART_8N2 = 2'b01;
  localparam logic [1:0] UART_8E1 = 2'b10;
  localparam logic [1:0] UART_8O1 = 2'b11;

  // Below four clocks per bit the mid-bit sample point collapses onto the
  // bit edges, so smaller dividers are raised to this value.
  localparam int DIV_MIN = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5,
    DONE   = 3'd6
  } uart_state_e;

endpackage

// File: rtl/uart_rx_deframer_if.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer_if
// Byte stream from the deframer to its consumer (udm).
//   data_o  : received byte
//   valid_o : data_o holds an unconsumed byte
//   ready_i : consumer accepts
// Handshake: a byte transfers on every clock edge where valid_o && ready_i.
// Once raised, valid_o and data_o hold steady until that transfer happens;
// valid_o never depends combinationally on ready_i.
// master = producer (deframer), slave = consumer.
// ---------------------------------------------------------------------------
interface uart_rx_deframer_if;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;

  modport master (output data_o, output valid_o, input ready_i);
  modport slave  (input data_o, input valid_o, output ready_i);
endinterface

// File: rtl/sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
// Multi-flop synchroniser for a single asynchronous input. The flops reset
// to 1 so that an idle UART line reads as idle straight out of reset.
//   clk_i   : destination clock
//   rst_n_i : asynchronous active-low reset
//   d_i     : asynchronous input
//   q_o     : synchronised output (STAGES cycles of latency)
// ---------------------------------------------------------------------------
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= '1;
    else          sync_q <= sync_d;
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer
// UART receive front end: synchronises rx_i, validates the start bit,
// samples each bit at its midpoint, checks parity/stop bits and hands bytes
// to the consumer through a single-entry holding register.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   rx_i           : raw UART line (idle high)
//   divider_i      : clocks per bit, latched at start-bit detection
//   cfg_i          : frame format (uart_pkg UART_*), latched at start-bit
//   rx_if          : byte stream (data_o / valid_o / ready_i)
//   frame_err_o    : one-cycle pulse, a stop bit was sampled low
//   parity_err_o   : one-cycle pulse, parity mismatch
//   overrun_o      : one-cycle pulse, new byte dropped (holding reg full)
//   busy_o         : FSM is not in IDLE
//   state_o        : current FSM state (debug)
// ---------------------------------------------------------------------------
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 rx_i,
  input  logic [DIV_WIDTH-1:0] divider_i,
  input  logic [1:0]           cfg_i,
  uart_rx_deframer_if.master   rx_if,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o,
  output logic                 busy_o,
  output uart_state_e          state_o
);

  logic rx_s;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (rx_i),
    .q_o     (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [1:0]           cfg_q, cfg_d;
  logic [2:0]           bidx_q, bidx_d;
  logic [7:0]           shreg_q, shreg_d;
  logic                 rx_prev_q, rx_prev_d;
  logic                 ferr_q, ferr_d;     // stop-bit error recorded this frame
  logic                 perr_q, perr_d;     // parity error recorded this frame
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;

  logic [DIV_WIDTH-1:0] eff_div;
  logic                 exp_parity;

  assign eff_div    = (divider_i < DIV_WIDTH'(DIV_MIN)) ? DIV_WIDTH'(DIV_MIN) : divider_i;
  assign exp_parity = (cfg_q == UART_8O1) ? ~^shreg_q : ^shreg_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    cfg_d        = cfg_q;
    bidx_d       = bidx_q;
    shreg_d      = shreg_q;
    rx_prev_d    = rx_s;
    ferr_d       = ferr_q;
    perr_d       = perr_q;
    data_d       = data_q;
    valid_d      = valid_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;

    if (valid_q && rx_if.ready_i) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Only a 1->0 edge starts a frame, so a held-low line (break)
        // cannot retrigger after its frame completes.
        if (rx_prev_q && !rx_s) begin
          div_d   = eff_div;
          cfg_d   = cfg_i;
          cnt_d   = eff_div >> 1;
          ferr_d  = 1'b0;
          perr_d  = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            state_d = IDLE;           // glitch, not a real start bit
          end else begin
            cnt_d   = div_q - DIV_WIDTH'(1);
            bidx_d  = 3'd0;
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shreg_d = {rx_s, shreg_q[7:1]};
          cnt_d   = div_q - DIV_WIDTH'(1);
          bidx_d  = bidx_q + 3'd1;
          if (bidx_q == 3'd7) state_d = cfg_q[1] ? PARITY : STOP1;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      PARITY: begin
        if (cnt_q == '0) begin
          perr_d  = (rx_s != exp_parity);
          cnt_d   = div_q - DIV_WIDTH'(1);
          state_d = STOP1;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      STOP1: begin
        // Leaving at mid-stop-bit re-arms IDLE half a bit early.
        if (cnt_q == '0) begin
          ferr_d = !rx_s;
          if (cfg_q == UART_8N2) begin
            cnt_d   = div_q - DIV_WIDTH'(1);
            state_d = STOP2;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      STOP2: begin
        if (cnt_q == '0) begin
          if (!rx_s) ferr_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - DIV_WIDTH'(1);
        end
      end
      DONE: begin
        // A byte accepted this very cycle frees the holding register, so
        // only a held, unaccepted byte causes the new one to be dropped.
        if (valid_q && !rx_if.ready_i) begin
          overrun_d = 1'b1;
        end else begin
          data_d  = shreg_q;
          valid_d = 1'b1;
        end
        frame_err_d  = ferr_q;
        parity_err_d = perr_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      div_q        <= '0;
      cfg_q        <= UART_8N1;
      bidx_q       <= 3'd0;
      shreg_q      <= 8'h00;
      rx_prev_q    <= 1'b1;
      ferr_q       <= 1'b0;
      perr_q       <= 1'b0;
      data_q       <= 8'h00;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      cfg_q        <= cfg_d;
      bidx_q       <= bidx_d;
      shreg_q      <= shreg_d;
      rx_prev_q    <= rx_prev_d;
      ferr_q       <= ferr_d;
      perr_q       <= perr_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_if.data_o  = data_q;
  assign rx_if.valid_o = valid_q;
  assign frame_err_o   = frame_err_q;
  assign parity_err_o  = parity_err_q;
  assign overrun_o     = overrun_q;
  assign busy_o        = (state_q != IDLE);
  assign state_o       = state_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deframer
// Directed bench for uart_rx_deframer: table of single frames with expected
// byte and error flags, plus hand-written back-to-back, glitch, overrun,
// reset-abort, divider clamp and mid-frame reconfiguration sequences.
// ---------------------------------------------------------------------------
module tb_uart_rx_deframer;
  import uart_pkg::*;

  localparam int DW  = 32;
  localparam int BIT = 16;   // clocks per bit for most frames

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic [DW-1:0] divider = 32'(BIT);
  logic [1:0]    cfg = UART_8N1;
  logic          frame_err, parity_err, overrun, busy;
  uart_state_e   state;

  always #5 clk = ~clk;

  uart_rx_deframer_if rx_if ();

  uart_rx_deframer #(.DIV_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .rx_i         (rx),
    .divider_i    (divider),
    .cfg_i        (cfg),
    .rx_if        (rx_if),
    .frame_err_o  (frame_err),
    .parity_err_o (parity_err),
    .overrun_o    (overrun),
    .busy_o       (busy),
    .state_o      (state)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  int         xfer_cnt = 0, ferr_cnt = 0, perr_cnt = 0, ovr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_if.valid_o && rx_if.ready_i) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no transfer", rx_if.data_o);
        end else begin
          check("byte", 32'(rx_if.data_o), 32'(exp_q.pop_front()));
        end
      end
      if (frame_err)  ferr_cnt++;
      if (parity_err) perr_cnt++;
      if (overrun)    ovr_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    wait_clks(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] fmt, input logic par,
                            input logic s1, input logic s2, input int n);
    drive_bit(1'b0, n);
    for (int i = 0; i < 8; i++) drive_bit(d[i], n);
    if (fmt[1]) drive_bit(par, n);
    drive_bit(s1, n);
    if (fmt == UART_8N2) drive_bit(s2, n);
    rx = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic [1:0] fmt;
    logic       par_bit;
    logic       stop1;
    logic       stop2;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[10];
  int   x0, f0, p0, o0;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    //            data   fmt       par   s1    s2    perr  ferr
    vecs[0] = '{8'h55, UART_8N1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'hA3, UART_8N1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h07, UART_8E1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};  // 3 ones: even bit 1
    vecs[3] = '{8'h07, UART_8E1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h07, UART_8O1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};  // odd bit 0
    vecs[5] = '{8'hC3, UART_8O1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};  // 4 ones: odd bit 1
    vecs[6] = '{8'hC3, UART_8E1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{8'h96, UART_8N2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{8'h96, UART_8N2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};  // second stop low
    vecs[9] = '{8'h3E, UART_8N1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};  // stop low

    rx_if.ready_i = 1'b1;

    // reset state
    wait_clks(3);
    check("rst_valid", 32'(rx_if.valid_o), 32'd0);
    check("rst_data", 32'(rx_if.data_o), 32'd0);
    check("rst_flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));
    rst_n = 1'b1;
    wait_clks(5);

    // table-driven single frames
    for (int v = 0; v < 10; v++) begin
      x0 = xfer_cnt; f0 = ferr_cnt; p0 = perr_cnt; o0 = ovr_cnt;
      cfg = vecs[v].fmt;
      exp_q.push_back(vecs[v].data);
      send_frame(vecs[v].data, vecs[v].fmt, vecs[v].par_bit, vecs[v].stop1, vecs[v].stop2, BIT);
      wait_clks(2 * BIT);
      check($sformatf("vec%0d_xfer", v), 32'(xfer_cnt - x0), 32'd1);
      check($sformatf("vec%0d_perr", v), 32'(perr_cnt - p0), 32'(vecs[v].exp_perr));
      check($sformatf("vec%0d_ferr", v), 32'(ferr_cnt - f0), 32'(vecs[v].exp_ferr));
      check($sformatf("vec%0d_ovr", v), 32'(ovr_cnt - o0), 32'd0);
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
    end

    // back-to-back 8N1 frames
    cfg = UART_8N1;
    x0 = xfer_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hA3);
    send_frame(8'h55, UART_8N1, 1'b0, 1'b1, 1'b1, BIT);
    send_frame(8'hA3, UART_8N1, 1'b0, 1'b1, 1'b1, BIT);
    wait_clks(2 * BIT);
    check("b2b_xfer", 32'(xfer_cnt - x0), 32'd2);
    check("b2b_flags", 32'((ferr_cnt - f0) + (perr_cnt - p0)), 32'd0);
    check("b2b_drained", 32'(exp_q.size()), 32'd0);

    // 0.3-bit glitch on an idle line: start rejected
    x0 = xfer_cnt;
    rx = 1'b0;
    wait_clks(5);
    rx = 1'b1;
    wait_clks(3);
    check("glitch_busy_seen", 32'(busy), 32'd1);
    wait_clks(2 * BIT);
    check("glitch_busy_low", 32'(busy), 32'd0);
    check("glitch_no_xfer", 32'(xfer_cnt - x0), 32'd0);

    // overrun: consumer stalled across two frames
    rx_if.ready_i = 1'b0;
    o0 = ovr_cnt; x0 = xfer_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, UART_8N1, 1'b0, 1'b1, 1'b1, BIT);
    send_frame(8'h22, UART_8N1, 1'b0, 1'b1, 1'b1, BIT);
    wait_clks(2 * BIT);
    check("ovr_valid", 32'(rx_if.valid_o), 32'd1);
    check("ovr_data", 32'(rx_if.data_o), 32'h11);
    check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    check("ovr_no_xfer", 32'(xfer_cnt - x0), 32'd0);
    rx_if.ready_i = 1'b1;
    wait_clks(1);
    check("ovr_valid_drop", 32'(rx_if.valid_o), 32'd0);
    check("ovr_xfer", 32'(xfer_cnt - x0), 32'd1);

    // reset during bit 4 of 0x5A, transmitter abandons the frame
    x0 = xfer_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    drive_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h5A >> i), BIT);
    rx = 1'b1;                     // bit 4 of 0x5A
    wait_clks(BIT / 2);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_state", 32'(state), 32'(IDLE));
    check("abort_valid", 32'(rx_if.valid_o), 32'd0);
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(12 * BIT);
    check("abort_no_xfer", 32'(xfer_cnt - x0), 32'd0);
    check("abort_no_flags", 32'((ferr_cnt - f0) + (perr_cnt - p0)), 32'd0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, UART_8N1, 1'b0, 1'b1, 1'b1, BIT);
    wait_clks(2 * BIT);
    check("after_abort_xfer", 32'(xfer_cnt - x0), 32'd1);

    // divider 2 clamps to 4
    x0 = xfer_cnt; f0 = ferr_cnt;
    divider = 32'd2;
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, UART_8N1, 1'b0, 1'b1, 1'b1, 4);
    wait_clks(20);
    check("clamp_xfer", 32'(xfer_cnt - x0), 32'd1);
    check("clamp_ferr", 32'(ferr_cnt - f0), 32'd0);

    // divider/cfg change mid-frame does not affect the current byte
    divider = 32'(BIT);
    cfg = UART_8N1;
    x0 = xfer_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    exp_q.push_back(8'h69);
    fork
      send_frame(8'h69, UART_8N1, 1'b0, 1'b1, 1'b1, BIT);
      begin
        wait_clks(3 * BIT);
        divider = 32'd5;
        cfg = UART_8E1;
      end
    join
    wait_clks(2 * BIT);
    check("midchg_xfer", 32'(xfer_cnt - x0), 32'd1);
    check("midchg_flags", 32'((ferr_cnt - f0) + (perr_cnt - p0)), 32'd0);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
